// File: rtl/pipe_resp_drop_unit.sv
// Response-side drop filter: discards memory responses that belong to squashed
// requests, in arrival order, tracking up to p_max_drops owed discards.
module pipe_resp_drop_unit #(
  parameter int p_msg_nbits = 32,
  parameter int p_max_drops = 3,
  localparam int c_cnt_nbits = $clog2(p_max_drops + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   drop,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_val,
  output logic                   in_rdy,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [c_cnt_nbits-1:0] pending,
  output logic                   overflow
);

  localparam logic [c_cnt_nbits:0]   c_max_eff = (c_cnt_nbits + 1)'(p_max_drops);
  localparam logic [c_cnt_nbits:0]   c_one_eff = (c_cnt_nbits + 1)'(1);
  localparam logic [c_cnt_nbits-1:0] c_max_cnt = c_cnt_nbits'(p_max_drops);

  logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [c_cnt_nbits:0]   eff;
  logic                   discard;

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    // One bit wider than cnt so a drop on top of a full counter is visible.
    eff     = {1'b0, cnt_q} + {{c_cnt_nbits{1'b0}}, drop};
    discard = in_val && (eff != '0);
    in_rdy  = out_rdy;
    out_val = in_val;
    cnt_d   = c_cnt_nbits'(eff);
    ovf_d   = ovf_q;
    if (discard) begin
      // Consume regardless of out_rdy; eff-1 can never exceed p_max_drops.
      in_rdy  = 1'b1;
      out_val = 1'b0;
      cnt_d   = c_cnt_nbits'(eff - c_one_eff);
    end else if (eff > c_max_eff) begin
      cnt_d = c_max_cnt;
      ovf_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_msg  = in_msg;
  assign pending  = cnt_q;
  assign overflow = ovf_q;

`ifndef SYNTHESIS
  drop_known_a: assert property (@(posedge clk) disable iff (reset) !$isunknown(drop));
`endif

endmodule

// File: tb/tb_pipe_resp_drop_unit.sv
// Scoreboard bench for pipe_resp_drop_unit: passing responses are queued when
// driven and popped when the pipeline side accepts them.
module tb_pipe_resp_drop_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drop = 1'b0;
  logic [31:0] in_msg = '0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [31:0] out_msg;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic [1:0]  pending;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];

  pipe_resp_drop_unit #(.p_msg_nbits(32), .p_max_drops(3)) dut (
    .clk(clk), .reset(reset), .drop(drop),
    .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
    .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs just after a rising edge, then settle to the falling edge.
  task automatic drive(input logic d, input logic v, input logic r, input logic [31:0] m);
    drop = d; in_val = v; out_rdy = r; in_msg = m;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drop = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_msg = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0);
      tick();
    end
  endtask

  // Output monitor: every accepted response must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && out_val && out_rdy) begin
      if (sb_q.size() == 0) check("sb_unexpected", out_msg, 32'hFFFF_FFFF ^ out_msg);
      else check("sb_msg", out_msg, sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("rst_pending", 32'(pending), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(1);

    // Pass-through, ready and not ready.
    sb_q.push_back(32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    check("pass_out_val", 32'(out_val), 1);
    check("pass_out_msg", out_msg, 32'hDEADBEEF);
    check("pass_in_rdy", 32'(in_rdy), 1);
    tick();
    check("pass_pending", 32'(pending), 0);
    drive(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    check("stall_in_rdy", 32'(in_rdy), 0);
    check("stall_out_val", 32'(out_val), 1);
    tick();

    // Same-cycle drop, then the following response passes.
    drive(1'b1, 1'b1, 1'b1, 32'h11);
    check("same_out_val", 32'(out_val), 0);
    check("same_in_rdy", 32'(in_rdy), 1);
    tick();
    check("same_pending", 32'(pending), 0);
    sb_q.push_back(32'h22);
    drive(1'b0, 1'b1, 1'b1, 32'h22);
    check("next_out_val", 32'(out_val), 1);
    tick();

    // Deferred drops on cycles 1 and 3.
    drive(1'b1, 1'b0, 1'b0, '0); tick();
    check("defer_pending1", 32'(pending), 1);
    idle_cycles(1);
    drive(1'b1, 1'b0, 1'b0, '0); tick();
    check("defer_pending2", 32'(pending), 2);
    drive(1'b0, 1'b1, 1'b0, 32'hA);
    check("defer_a_out_val", 32'(out_val), 0);
    check("defer_a_in_rdy", 32'(in_rdy), 1);
    tick();
    check("defer_a_pending", 32'(pending), 1);
    drive(1'b0, 1'b1, 1'b0, 32'hB);
    check("defer_b_out_val", 32'(out_val), 0);
    check("defer_b_in_rdy", 32'(in_rdy), 1);
    tick();
    check("defer_b_pending", 32'(pending), 0);
    drive(1'b0, 1'b1, 1'b0, 32'hC);
    check("defer_c_out_val", 32'(out_val), 1);
    check("defer_c_in_rdy", 32'(in_rdy), 0);
    tick();
    sb_q.push_back(32'hC);
    drive(1'b0, 1'b1, 1'b1, 32'hC);
    check("defer_c_rdy", 32'(in_rdy), 1);
    tick();

    // Held response squashed while stalled.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h55);
      check("held_in_rdy", 32'(in_rdy), 0);
      check("held_out_val", 32'(out_val), 1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h55);
    check("squash_in_rdy", 32'(in_rdy), 1);
    check("squash_out_val", 32'(out_val), 0);
    tick();
    check("squash_pending", 32'(pending), 0);

    // Saturation: four drops against a limit of three.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0); tick();
      check("sat_pending", 32'(pending), (i > 3) ? 3 : i);
      check("sat_overflow", 32'(overflow), (i > 3) ? 1 : 0);
    end
    for (int i = 2; i >= 0; i--) begin
      drive(1'b0, 1'b1, 1'b1, 32'h100 + 32'(i));
      check("sat_disc_out_val", 32'(out_val), 0);
      tick();
      check("sat_disc_pending", 32'(pending), i);
      check("sat_disc_overflow", 32'(overflow), 1);
    end
    sb_q.push_back(32'h33);
    drive(1'b0, 1'b1, 1'b1, 32'h33);
    check("sat_after_out_val", 32'(out_val), 1);
    tick();

    // Asynchronous reset mid-cycle with drops owed.
    drive(1'b1, 1'b0, 1'b0, '0); tick();
    drive(1'b1, 1'b0, 1'b0, '0); tick();
    check("ar_pending_before", 32'(pending), 2);
    #2 reset = 1'b1;
    #1;
    check("ar_pending", 32'(pending), 0);
    check("ar_overflow", 32'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    sb_q.push_back(32'h77);
    drive(1'b0, 1'b1, 1'b1, 32'h77);
    check("ar_out_val", 32'(out_val), 1);
    check("ar_out_msg", out_msg, 32'h77);
    tick();
    idle_cycles(2);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
